// File: rtl/slavefifo_pkg.sv
// Shared Slave FIFO definitions: state encodings for both stream directions,
// the default bus width and the counter-width helper.
package slavefifo_pkg;

    localparam int SLAVEFIFO_DATA_W = 32;

    typedef enum logic [2:0] {
        SIN_IDLE       = 3'd0,
        SIN_FLAGA_RCVD = 3'd1,
        SIN_WAIT_FLAGB = 3'd2,
        SIN_WRITE      = 3'd3,
        SIN_WR_DELAY   = 3'd4,
        SIN_PKTEND     = 3'd5
    } stream_in_state_t;

    // Stream-OUT read engine encodings, kept here so both engines share one package
    typedef enum logic [2:0] {
        SOUT_IDLE          = 3'd0,
        SOUT_FLAGC_RCVD    = 3'd1,
        SOUT_WAIT_FLAGD    = 3'd2,
        SOUT_READ          = 3'd3,
        SOUT_READ_RD_DELAY = 3'd4,
        SOUT_READ_OE_DELAY = 3'd5
    } stream_out_state_t;

    function automatic int cnt_width(input int words);
        return (words > 2) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/slavefifo_wr_timer.sv
// Loadable down-counter for the post-watermark hold; in up_mode it counts up
// and saturates at sat_val, which serves the source idle counter.
module slavefifo_wr_timer #(
    parameter int W = 2
) (
    input  logic         clk_100,
    input  logic         reset_,
    input  logic         up_mode,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] sat_val,
    output logic [W-1:0] count
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] cnt, input logic [W-1:0] lim);
        return (cnt == lim) ? cnt : cnt + W'(1);
    endfunction

    function automatic logic [W-1:0] floor_dec(input logic [W-1:0] cnt);
        return (cnt == '0) ? cnt : cnt - W'(1);
    endfunction

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up_mode ? sat_inc(count, sat_val) : floor_dec(count);
        end
    end

endmodule

// File: rtl/slavefifo2b_stream_in.sv
// FX3 Slave FIFO stream-IN write engine (valid/ready source -> SLWR#/PKTEND#).
// Define SLAVEFIFO_PKTEND_EN to enable the idle-timeout short-packet commit.
module slavefifo2b_stream_in
    import slavefifo_pkg::*;
#(
    parameter int DATA_W       = SLAVEFIFO_DATA_W,
    parameter int WR_DELAY     = 2,
    parameter int BUF_WORDS    = 256,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic              clk_100,
    input  logic              reset_,
    input  logic              stream_in_mode_selected,
    input  logic              flaga_d,
    input  logic              flagb_d,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              slwr_streamIN_,
    output logic              pktend_streamIN_,
    output logic [DATA_W-1:0] stream_in_data_to_fx3,
    output logic              writing
);

    localparam int CNT_W  = cnt_width(BUF_WORDS);
    localparam int DLY_W  = 2;
    localparam int IDLE_W = cnt_width(IDLE_TIMEOUT);

    if (WR_DELAY < 1 || WR_DELAY > 3) begin : g_bad_wr_delay
        $error("WR_DELAY must be in 1..3");
    end
    if (BUF_WORDS < 2 || (BUF_WORDS & (BUF_WORDS - 1)) != 0) begin : g_bad_buf_words
        $error("BUF_WORDS must be a power of two, at least 2");
    end
    if (IDLE_TIMEOUT < 2) begin : g_bad_idle_timeout
        $error("IDLE_TIMEOUT must be at least 2");
    end

    stream_in_state_t state;
    logic [CNT_W-1:0] word_cnt;
    logic             vld_p0;
    logic             dly_load;
    logic             dly_en;
    logic [DLY_W-1:0] dly_cnt;
    logic             commit_ok;
    logic             idle_timeout;

    assign src_ready = (state == SIN_WRITE) & flagb_d & stream_in_mode_selected;
    assign vld_p0    = src_valid & src_ready;
    assign writing   = (state == SIN_WRITE);
    assign dly_load  = (state == SIN_WRITE) & ~flagb_d;
    assign dly_en    = (state == SIN_WR_DELAY);

    slavefifo_wr_timer #(.W(DLY_W)) u_dly_timer (
        .clk_100  (clk_100),
        .reset_   (reset_),
        .up_mode  (1'b0),
        .clear    (1'b0),
        .load     (dly_load),
        .load_val (DLY_W'(WR_DELAY - 1)),
        .en       (dly_en),
        .sat_val  ({DLY_W{1'b0}}),
        .count    (dly_cnt)
    );

`ifdef SLAVEFIFO_PKTEND_EN
    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_clr;

    // Any accepted word, or leaving WRITE, restarts the quiet-period count
    assign idle_clr = vld_p0 | (state != SIN_WRITE);

    slavefifo_wr_timer #(.W(IDLE_W)) u_idle_timer (
        .clk_100  (clk_100),
        .reset_   (reset_),
        .up_mode  (1'b1),
        .clear    (idle_clr),
        .load     (1'b0),
        .load_val ({IDLE_W{1'b0}}),
        .en       (~idle_clr),
        .sat_val  (IDLE_W'(IDLE_TIMEOUT - 1)),
        .count    (idle_cnt)
    );

    assign commit_ok    = (word_cnt != '0);
    assign idle_timeout = (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) & ~vld_p0;
`else
    assign commit_ok    = 1'b0;
    assign idle_timeout = 1'b0;
`endif

    // Stage p0 -> FX3 pins: one-cycle registered write, PKTEND# only after the last SLWR#
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            state                 <= SIN_IDLE;
            slwr_streamIN_        <= 1'b1;
            pktend_streamIN_      <= 1'b1;
            stream_in_data_to_fx3 <= '0;
            word_cnt              <= '0;
        end else begin
            slwr_streamIN_   <= ~vld_p0;
            pktend_streamIN_ <= 1'b1;
            if (vld_p0) begin
                stream_in_data_to_fx3 <= src_data;
                word_cnt              <= word_cnt + CNT_W'(1);
            end

            case (state)
                SIN_IDLE: begin
                    if (stream_in_mode_selected && flaga_d) begin
                        state <= SIN_FLAGA_RCVD;
                    end
                end
                SIN_FLAGA_RCVD: begin
                    state <= SIN_WAIT_FLAGB;
                end
                SIN_WAIT_FLAGB: begin
                    if (flagb_d) begin
                        state <= SIN_WRITE;
                    end
                end
                SIN_WRITE: begin
                    if (!flagb_d) begin
                        state <= SIN_WR_DELAY;
                    end else if (!stream_in_mode_selected) begin
                        if (commit_ok) begin
                            state            <= SIN_PKTEND;
                            pktend_streamIN_ <= 1'b0;
                        end else begin
                            state <= SIN_IDLE;
                        end
                    end else if (idle_timeout && commit_ok) begin
                        state            <= SIN_PKTEND;
                        pktend_streamIN_ <= 1'b0;
                    end
                end
                SIN_WR_DELAY: begin
                    if (dly_cnt == '0) begin
                        state <= SIN_IDLE;
                    end
                end
                SIN_PKTEND: begin
                    word_cnt <= '0;
                    state    <= SIN_IDLE;
                end
                default: begin
                    state <= SIN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slavefifo2b_stream_in.sv
// Bench for slavefifo2b_stream_in: behavioural model plus directed scenarios.
module tb_slavefifo2b_stream_in;

    localparam int DATA_W       = 32;
    localparam int WR_DELAY     = 2;
    localparam int BUF_WORDS    = 4;
    localparam int IDLE_TIMEOUT = 6;
`ifdef SLAVEFIFO_PKTEND_EN
    localparam int PK_ON = 1;
`else
    localparam int PK_ON = 0;
`endif

    logic              clk_100 = 1'b0;
    logic              reset_  = 1'b0;
    logic              mode    = 1'b0;
    logic              flaga   = 1'b0;
    logic              flagb   = 1'b0;
    logic              src_en  = 1'b0;
    int                src_idx = 0;
    int                src_lim = 0;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              slwr_;
    logic              pktend_;
    logic [DATA_W-1:0] dout;
    logic              writing;

    assign src_valid = src_en && (src_idx < src_lim);
    assign src_data  = DATA_W'(src_idx + 1);

    slavefifo2b_stream_in #(
        .DATA_W       (DATA_W),
        .WR_DELAY     (WR_DELAY),
        .BUF_WORDS    (BUF_WORDS),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk_100                 (clk_100),
        .reset_                  (reset_),
        .stream_in_mode_selected (mode),
        .flaga_d                 (flaga),
        .flagb_d                 (flagb),
        .src_valid               (src_valid),
        .src_data                (src_data),
        .src_ready               (src_ready),
        .slwr_streamIN_          (slwr_),
        .pktend_streamIN_        (pktend_),
        .stream_in_data_to_fx3   (dout),
        .writing                 (writing)
    );

    always #5 clk_100 = ~clk_100;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase of the write engine, words since last commit, quiet run length
    typedef enum {M_IDLE, M_ARMED, M_WAITB, M_WRITE, M_HOLD, M_COMMIT} mph_t;
    mph_t              ph      = M_IDLE;
    logic              m_slwr  = 1'b1;
    logic              m_pkt   = 1'b1;
    logic [DATA_W-1:0] m_data  = '0;
    int                m_words = 0;
    int                m_quiet = 0;
    int                m_left  = 0;

    always @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            ph = M_IDLE; m_slwr = 1'b1; m_pkt = 1'b1; m_data = '0;
            m_words = 0; m_quiet = 0; m_left = 0;
        end else begin
            logic take;
            mph_t was;
            take   = src_valid && (ph == M_WRITE) && flagb && mode;
            was    = ph;
            m_slwr = !take;
            m_pkt  = 1'b1;
            if (take) begin
                m_data  = src_data;
                m_words = m_words + 1;
                src_idx <= src_idx + 1;
            end
            case (ph)
                M_IDLE:  if (mode && flaga) ph = M_ARMED;
                M_ARMED: ph = M_WAITB;
                M_WAITB: if (flagb) ph = M_WRITE;
                M_WRITE: begin
                    if (!flagb) begin
                        ph = M_HOLD; m_left = WR_DELAY;
                    end else if (!mode) begin
                        if (PK_ON != 0 && (m_words % BUF_WORDS) != 0) begin ph = M_COMMIT; m_pkt = 1'b0; end
                        else ph = M_IDLE;
                    end else if (PK_ON != 0 && !take && m_quiet >= IDLE_TIMEOUT - 1
                                 && (m_words % BUF_WORDS) != 0) begin
                        ph = M_COMMIT; m_pkt = 1'b0;
                    end
                end
                M_HOLD: begin
                    m_left = m_left - 1;
                    if (m_left == 0) ph = M_IDLE;
                end
                M_COMMIT: begin m_words = 0; ph = M_IDLE; end
                default: ph = M_IDLE;
            endcase
            m_quiet = (was == M_WRITE && !take) ? m_quiet + 1 : 0;
        end
    end

    int   cyc        = 0;
    int   n_slwr     = 0;
    int   n_pk       = 0;
    int   last_wr    = -1;
    int   pk_cyc     = -1;
    int   rise_cyc   = -1;
    int   first_wr   = -1;
    logic prev_wr    = 1'b0;

    always @(negedge clk_100) begin
        cyc++;
        chk("slwr", slwr_, m_slwr);
        chk("pktend", pktend_, m_pkt);
        chk("data", dout, m_data);
        chk("writing", writing, ph == M_WRITE);
        chk("src_ready", src_ready, (ph == M_WRITE) && flagb && mode);
        if (writing && !prev_wr) begin rise_cyc = cyc; first_wr = -1; end
        prev_wr = writing;
        if (!slwr_) begin
            n_slwr++; last_wr = cyc;
            if (first_wr < 0) first_wr = cyc;
        end
        if (!pktend_) begin n_pk++; pk_cyc = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100);
        #2;
    endtask

    task automatic wait_idx(input string name, input int target, input int budget);
        int k = 0;
        while (src_idx < target && k < budget) begin tick(1); k++; end
        if (src_idx < target) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: wait expired, src_idx=%0d, expected %0d", name, src_idx, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pk0;
        tick(2);
        chk("rst_slwr", slwr_, 1'b1);
        chk("rst_pktend", pktend_, 1'b1);
        chk("rst_data", dout, 32'h0);
        chk("rst_ready", src_ready, 1'b0);
        chk("rst_writing", writing, 1'b0);
        reset_ = 1'b1;

        // Basic write, then watermark drop after 10 words with an 11th pending
        src_en = 1'b1; src_lim = 20; mode = 1'b1; flaga = 1'b1;
        tick(2);
        flagb = 1'b1;
        wait_idx("basic", 10, 40);
        flagb = 1'b0; flaga = 1'b0;
        chk("first_wr_latency", 32'(first_wr - rise_cyc), 32'd1);
        tick(4);
        chk("wmark_writes", 32'(n_slwr), 32'd10);
        chk("wmark_retained", 32'(src_idx), 32'd10);
        chk("wmark_idle", writing, 1'b0);

        src_lim = 12; flaga = 1'b1; flagb = 1'b1;
        wait_idx("rearm", 12, 30);
        tick(2);
        chk("rearm_writes", 32'(n_slwr), 32'd12);

        // Asynchronous reset in the middle of a burst
        src_lim = 40;
        tick(3);
        #1 reset_ = 1'b0;
        #1;
        chk("arst_slwr", slwr_, 1'b1);
        chk("arst_pktend", pktend_, 1'b1);
        chk("arst_data", dout, 32'h0);
        chk("arst_writing", writing, 1'b0);
        src_en = 1'b0; mode = 1'b0; flaga = 1'b0; flagb = 1'b0;
        tick(2);
        reset_ = 1'b1;

        // Buffer wrap: 9 words into a 4-word buffer, then the source goes quiet
        src_en = 1'b1; src_lim = src_idx + 9; mode = 1'b1; flaga = 1'b1; flagb = 1'b1;
        pk0 = n_pk;
        wait_idx("wrap", src_lim, 40);
        chk("wrap_word_cnt", 32'(dut.word_cnt), 32'd1);
        tick(IDLE_TIMEOUT + 4);
        chk("wrap_pktend_count", 32'(n_pk - pk0), 32'(PK_ON));
`ifdef SLAVEFIFO_PKTEND_EN
        chk("wrap_pktend_delay", 32'(pk_cyc - last_wr), 32'(IDLE_TIMEOUT));
`endif

        // Zero-length guard: exactly two full buffers, then mode drop
        reset_ = 1'b0;
        tick(1);
        reset_ = 1'b1;
        src_lim = src_idx + 8;
        pk0 = n_pk;
        wait_idx("zlp", src_lim, 40);
        mode = 1'b0;
        tick(4);
        chk("zlp_pktend_count", 32'(n_pk - pk0), 32'd0);
        chk("zlp_word_cnt", 32'(dut.word_cnt), 32'd0);
        chk("zlp_idle", writing, 1'b0);

        // Mode drop with a partial buffer
        mode = 1'b1; src_lim = src_idx + 3;
        pk0 = n_pk;
        wait_idx("partial", src_lim, 30);
        mode = 1'b0;
        tick(4);
        chk("partial_pktend_count", 32'(n_pk - pk0), 32'(PK_ON));
        chk("partial_word_cnt", 32'(dut.word_cnt), (PK_ON != 0) ? 32'd0 : 32'd3);
        chk("partial_idle", writing, 1'b0);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
